// File: rtl/mux_arb_pkg.sv
// Shared constants and state type for the 8-lane round-robin mux arbiter.
package mux_arb_pkg;
  localparam int unsigned NUM_REQ      = 8;
  localparam int unsigned SEL_W        = 3;
  localparam int unsigned HOLD_W       = 4;
  localparam int unsigned MAX_HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational circular priority encoder: first set req bit at or after ptr, wrapping 7->0.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);
  logic [2*NUM_REQ-2:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     off;

  // Rotate so that lane ptr lands at bit 0, then take the lowest set bit.
  assign dbl = {req[NUM_REQ-2:0], req};
  assign rot = dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign idx   = ptr + off;
  assign found = |req;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 bit-select mux among 8 requesters with bounded hold.
// Optional ARB_LOCK_EN macro adds a lock input that suppresses hold expiry.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
`ifdef ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               out
);
  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W-1:0]  pick_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_found;
  logic              held;
  logic              expired;
  logic              release_c;

  // While granted, the search starts just past the current lane so rotation is immediate.
  assign pick_ptr = (state == GRANT) ? sel + SEL_W'(1) : ptr;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ARB_LOCK_EN
  assign held = valid & lock & req[sel];
`else
  assign held = 1'b0;
`endif

  assign expired   = (hold_cnt == HOLD_W'(MAX_HOLD)) && !held;
  assign release_c = !req[sel] || expired;
  assign out       = valid & data_in[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            sel      <= pick_idx;
            grant    <= NUM_REQ'(1) << pick_idx;
            valid    <= 1'b1;
            hold_cnt <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr <= sel + SEL_W'(1);
            if (pick_found) begin
              sel      <= pick_idx;
              grant    <= NUM_REQ'(1) << pick_idx;
              hold_cnt <= HOLD_W'(1);
            end else begin
              state    <= IDLE;
              grant    <= '0;
              valid    <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus random traffic vs. a lane-level model.
module tb_mux8_rr_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       out;
`ifdef ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: which lane owns the mux, for how many cycles, and where the next search starts.
  int m_active;
  int m_sel;
  int m_cnt;
  int m_ptr;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .out     (out)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_active = 0;
    m_sel    = 0;
    m_cnt    = 0;
    m_ptr    = 0;
  endfunction

  function automatic void model_update();
    int p;
    if (m_active == 0) begin
      p = pick(req, m_ptr);
      if (p >= 0) begin
        m_active = 1;
        m_sel    = p;
        m_cnt    = 1;
      end
    end else if (!req[m_sel] || m_cnt == MAX_HOLD) begin
      m_ptr = (m_sel + 1) % 8;
      p     = pick(req, m_ptr);
      if (p >= 0) begin
        m_sel = p;
        m_cnt = 1;
      end else begin
        m_active = 0;
      end
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic logic [7:0] m_grant();
    logic [7:0] one;
    one = 8'd1;
    return (m_active != 0) ? (one << m_sel) : 8'h00;
  endfunction

  // Advance one clock; inputs are left untouched until after the model has consumed them.
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      req     = 8'($urandom);
      data_in = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({grant, sel, valid, out} !== 13'd0) begin
        failures++;
        $display("FAIL reset_hold: grant=%h sel=%0d valid=%b out=%b, required all zero", grant, sel, valid, out);
      end
    end
    req = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req     = 8'h04;
    data_in = 8'h04;
    tick();
    checks++;
    if (grant !== 8'h04 || sel !== 3'd2 || valid !== 1'b1 || out !== 1'b1) begin
      failures++;
      $display("FAIL single_first: grant=%h sel=%0d valid=%b out=%b, required 04/2/1/1", grant, sel, valid, out);
    end
    data_in = 8'h00;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL single_out_comb: out=%b, required 0", out);
    end
    data_in = 8'h04;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || sel !== 3'd2 || grant !== 8'h04) begin
        failures++;
        $display("FAIL single_regrant cyc%0d: valid=%b sel=%0d grant=%h, required 1/2/04", i, valid, sel, grant);
      end
    end
    req = 8'h00;
    tick();
    checks++;
    if (valid !== 1'b0 || grant !== 8'h00 || out !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: valid=%b grant=%h out=%b, required 0/00/0", valid, grant, out);
    end
  endtask

  task automatic test_round_robin();
    int cnt [8];
    int exp_sel;
    logic [7:0] one;
    one = 8'd1;
    foreach (cnt[k]) cnt[k] = 0;
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_sel = (i / MAX_HOLD) % 8;
      checks++;
      if (valid !== 1'b1 || sel !== 3'(exp_sel) || grant !== (one << exp_sel) || out !== data_in[exp_sel]) begin
        failures++;
        $display("FAIL rr_seq cyc%0d: valid=%b sel=%0d grant=%h out=%b, required sel=%0d", i, valid, sel, grant, out, exp_sel);
      end
      cnt[sel]++;
      data_in = 8'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cnt[k] !== MAX_HOLD) begin
        failures++;
        $display("FAIL rr_share lane%0d: cycles=%0d, required %0d", k, cnt[k], MAX_HOLD);
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    req = 8'b0100_1000;
    tick();
    checks++;
    if (sel !== 3'd3 || grant !== 8'h08) begin
      failures++;
      $display("FAIL early_first: sel=%0d grant=%h, required 3/08", sel, grant);
    end
    tick();
    req = 8'b0100_0000;
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd6 || grant !== 8'h40) begin
      failures++;
      $display("FAIL early_switch: valid=%b sel=%0d grant=%h, required 1/6/40", valid, sel, grant);
    end
  endtask

  task automatic test_wrap();
    req = 8'b1000_0001;
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd7 || grant !== 8'h80) begin
      failures++;
      $display("FAIL wrap_seven: valid=%b sel=%0d grant=%h, required 1/7/80", valid, sel, grant);
    end
    req = 8'b0000_0001;
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd0 || grant !== 8'h01) begin
      failures++;
      $display("FAIL wrap_zero: valid=%b sel=%0d grant=%h, required 1/0/01", valid, sel, grant);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req     = 8'h20;
    data_in = 8'hFF;
    tick();
    tick();
    checks++;
    if (sel !== 3'd5 || valid !== 1'b1 || out !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: sel=%0d valid=%b out=%b, required 5/1/1", sel, valid, out);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({grant, sel, valid, out} !== 13'd0) begin
      failures++;
      $display("FAIL areset_now: grant=%h sel=%0d valid=%b out=%b, required all zero", grant, sel, valid, out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'hFF;
    tick();
    checks++;
    if (valid !== 1'b1 || sel !== 3'd0 || grant !== 8'h01) begin
      failures++;
      $display("FAIL areset_ptr: valid=%b sel=%0d grant=%h, required 1/0/01", valid, sel, grant);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    req     = 8'h00;
    data_in = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      data_in = 8'($urandom);
      tick();
      checks++;
      if (grant !== m_grant() || valid !== 1'(m_active != 0)) begin
        failures++;
        $display("FAIL rand_grant cyc%0d: grant=%h valid=%b, required %h/%0d", i, grant, valid, m_grant(), m_active);
      end
      checks++;
      if ((m_active != 0 && sel !== 3'(m_sel)) || out !== ((m_active != 0) ? data_in[m_sel] : 1'b0)) begin
        failures++;
        $display("FAIL rand_sel_out cyc%0d: sel=%0d out=%b, required sel=%0d", i, sel, out, m_sel);
      end
    end
  endtask

  initial begin
    req     = 8'h00;
    data_in = 8'h00;
    rst_n   = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
